// File: rtl/mcu_seq_if.sv
// mcu_seq_if: sequencer <-> pc / decoder / datapath bundle.
// master = sequencer side, slave = surrounding MCU side.
`ifndef INST_DEPTH
`define INST_DEPTH 8
`endif

interface mcu_seq_if #(
   parameter int INST_DEPTH = `INST_DEPTH,
   parameter int SP_W       = 2
);
   logic                  run;
   logic [INST_DEPTH-1:0] pc_addr;
   logic                  dec_halt;
   logic                  dec_ret;
   logic                  dec_call;
   logic                  dec_jmp;
   logic                  dec_jz;
   logic [INST_DEPTH-1:0] dec_target;
   logic                  zero;
   logic                  busy;
   logic                  pc_count;
   logic                  pc_load;
   logic [INST_DEPTH-1:0] pc_addr_in;
   logic                  ir_load;
   logic                  exec_en;
   logic                  halted;
   logic                  err;
   logic [SP_W:0]         stack_lvl;

   modport master (
      input  run, pc_addr, dec_halt, dec_ret, dec_call,
      input  dec_jmp, dec_jz, dec_target, zero, busy,
      output pc_count, pc_load, pc_addr_in, ir_load,
      output exec_en, halted, err, stack_lvl
   );

   modport slave (
      output run, pc_addr, dec_halt, dec_ret, dec_call,
      output dec_jmp, dec_jz, dec_target, zero, busy,
      input  pc_count, pc_load, pc_addr_in, ir_load,
      input  exec_en, halted, err, stack_lvl
   );
endinterface

// File: rtl/mcu_seq.sv
// mcu_seq: fetch/decode/execute sequencer, sole driver of the pc
// controls, with a small return-address stack for call/ret.
`ifndef INST_DEPTH
`define INST_DEPTH 8
`endif

module mcu_seq #(
   parameter int INST_DEPTH = `INST_DEPTH,
   parameter int SP_W       = 2
) (
   input  logic      clk,
   input  logic      rst,
   mcu_seq_if.master bus
);
   localparam int DEPTH = 2 ** SP_W;

   typedef enum logic [1:0] {
      FETCH, DECODE, EXEC, HALT
   } state_t;

   state_t                state;
   logic [INST_DEPTH-1:0] stack [DEPTH];
   logic [SP_W:0]         lvl;
   logic [INST_DEPTH-1:0] held;
   logic                  halted_q;
   logic                  err_q;

   logic                  empty;
   logic                  full;
   logic [SP_W-1:0]       wr_idx;
   logic [SP_W-1:0]       rd_idx;
   logic [INST_DEPTH-1:0] ret_addr;
   logic                  do_halt;
   logic                  do_err;
   logic                  do_pop;
   logic                  do_push;
   logic                  ld;
   logic                  cnt;
   logic [INST_DEPTH-1:0] ld_val;

   assign empty    = (lvl == '0);
   assign full     = (lvl == (SP_W+1)'(DEPTH));
   assign wr_idx   = lvl[SP_W-1:0];
   assign rd_idx   = lvl[SP_W-1:0] - SP_W'(1);
   assign ret_addr = bus.pc_addr + INST_DEPTH'(1);

   // Resolve the instruction in the EXEC exit cycle, halt > ret > call > jmp > jz.
   always_comb begin
      do_halt = 1'b0;
      do_err  = 1'b0;
      do_pop  = 1'b0;
      do_push = 1'b0;
      ld      = 1'b0;
      cnt     = 1'b0;
      ld_val  = held;
      if (state == EXEC && !bus.busy && !rst) begin
         if (bus.dec_halt) begin
            do_halt = 1'b1;
         end else if (bus.dec_ret) begin
            if (empty) begin
               do_halt = 1'b1;
               do_err  = 1'b1;
            end else begin
               do_pop = 1'b1;
               ld     = 1'b1;
               ld_val = stack[rd_idx];
            end
         end else if (bus.dec_call) begin
            if (full) begin
               do_halt = 1'b1;
               do_err  = 1'b1;
            end else begin
               do_push = 1'b1;
               ld      = 1'b1;
               ld_val  = bus.dec_target;
            end
         end else if (bus.dec_jmp || (bus.dec_jz && bus.zero)) begin
            ld     = 1'b1;
            ld_val = bus.dec_target;
         end else begin
            cnt = 1'b1;
         end
      end
   end

   assign bus.pc_count   = cnt;
   assign bus.pc_load    = ld;
   assign bus.pc_addr_in = rst ? '0 : ld_val;
   assign bus.ir_load    = (state == DECODE) && !rst;
   assign bus.exec_en    = (state == EXEC) && !rst;
   assign bus.halted     = halted_q;
   assign bus.err        = err_q;
   assign bus.stack_lvl  = lvl;

   // Sequencer FSM with stack level, sticky error and held load address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FETCH;
         lvl      <= '0;
         held     <= '0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         unique case (state)
            FETCH:  if (bus.run) state <= DECODE;
            DECODE: state <= EXEC;
            EXEC: begin
               if (!bus.busy) begin
                  state    <= do_halt ? HALT : FETCH;
                  halted_q <= do_halt;
               end
            end
            HALT:   state <= HALT;
         endcase
         if (do_err)  err_q <= 1'b1;
         if (ld)      held  <= ld_val;
         if (do_push) lvl   <= lvl + (SP_W+1)'(1);
         if (do_pop)  lvl   <= lvl - (SP_W+1)'(1);
      end
   end

   // Return-address storage; contents are don't-care beyond lvl.
   always_ff @(posedge clk) begin
      if (do_push) stack[wr_idx] <= ret_addr;
   end
endmodule

// File: tb/tb_mcu_seq.sv
// tb_mcu_seq: directed scenarios for mcu_seq with a simple pc model.
// Decode flags are driven directly in place of an instruction memory.
`timescale 1ns/1ps

module tb_mcu_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pc;
   int         checks = 0;
   int         errors = 0;
   int         n_cnt, n_ld, n_ir, n_ex, n_both, cyc;
   logic [7:0] last_ai;

   mcu_seq_if #(.INST_DEPTH(8), .SP_W(2)) bus ();

   mcu_seq #(.INST_DEPTH(8), .SP_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.pc_addr = pc;

   // Program counter model: load wins over count.
   always_ff @(posedge clk) begin
      if (rst)               pc <= 8'h00;
      else if (bus.pc_load)  pc <= bus.pc_addr_in;
      else if (bus.pc_count) pc <= pc + 8'h01;
   end

   task automatic clear_cnt();
      n_cnt = 0; n_ld = 0; n_ir = 0; n_ex = 0; n_both = 0; cyc = 0;
      last_ai = 8'hxx;
   endtask

   task automatic sample();
      #1;
      cyc++;
      if (bus.pc_count) n_cnt++;
      if (bus.pc_load) begin n_ld++; last_ai = bus.pc_addr_in; end
      if (bus.pc_count && bus.pc_load) n_both++;
      if (bus.ir_load) n_ir++;
      if (bus.exec_en) n_ex++;
   endtask

   task automatic idle_inputs();
      bus.dec_halt = 0; bus.dec_ret = 0; bus.dec_call = 0;
      bus.dec_jmp = 0; bus.dec_jz = 0; bus.dec_target = 8'h00;
      bus.zero = 0; bus.busy = 0;
   endtask

   // One instruction from FETCH; fl = {halt,ret,call,jmp,jz}.
   task automatic do_instr(input logic [4:0] fl, input logic [7:0] tgt,
                           input logic zf, input int nb);
      clear_cnt();
      bus.run = 1'b1;
      sample();
      @(negedge clk);
      bus.run = 1'b0;
      {bus.dec_halt, bus.dec_ret, bus.dec_call, bus.dec_jmp, bus.dec_jz} = fl;
      bus.dec_target = tgt;
      bus.zero = zf;
      sample();
      @(negedge clk);
      for (int k = 0; k <= nb; k++) begin
         bus.busy = (k < nb);
         sample();
         @(negedge clk);
      end
      idle_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1; bus.run = 1'b0; idle_inputs();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.run = 1'b1; idle_inputs();
      @(negedge clk);
      #1;
      checks++;
      if ({bus.pc_count, bus.pc_load, bus.ir_load, bus.exec_en,
           bus.halted, bus.err} !== 6'b0) begin
         errors++;
         $display("FAIL rst_outs got %b want 000000", {bus.pc_count,
                  bus.pc_load, bus.ir_load, bus.exec_en, bus.halted, bus.err});
      end
      checks++;
      if (bus.stack_lvl !== 3'd0) begin
         errors++; $display("FAIL rst_lvl got %0d want 0", bus.stack_lvl);
      end
      checks++;
      if (bus.pc_addr_in !== 8'h00) begin
         errors++; $display("FAIL rst_ai got %h want 00", bus.pc_addr_in);
      end
      @(negedge clk);
      rst = 1'b0; bus.run = 1'b0;
   endtask

   task automatic test_seq();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (pc !== 8'(i)) begin
            errors++; $display("FAIL seq%0d_pc0 got %h want %h", i, pc, 8'(i));
         end
         do_instr(5'b0, 8'h00, 1'b0, 0);
         checks++;
         if (cyc !== 3 || n_cnt !== 1 || n_ld !== 0) begin
            errors++;
            $display("FAIL seq%0d_strobe got cyc=%0d cnt=%0d ld=%0d want 3 1 0",
                     i, cyc, n_cnt, n_ld);
         end
         checks++;
         if (n_ir !== 1 || n_ex !== 1) begin
            errors++;
            $display("FAIL seq%0d_ir_ex got %0d %0d want 1 1", i, n_ir, n_ex);
         end
         checks++;
         if (pc !== 8'(i + 1)) begin
            errors++; $display("FAIL seq%0d_pc1 got %h want %h", i, pc, 8'(i+1));
         end
      end
   endtask

   task automatic test_jumps();
      do_instr(5'b00010, 8'h3F, 1'b0, 0);
      checks++;
      if (n_ld !== 1 || n_cnt !== 0 || last_ai !== 8'h3F) begin
         errors++;
         $display("FAIL jmp got ld=%0d cnt=%0d ai=%h want 1 0 3f", n_ld, n_cnt, last_ai);
      end
      checks++;
      if (pc !== 8'h3F) begin errors++; $display("FAIL jmp_pc got %h want 3f", pc); end
      do_instr(5'b00001, 8'h77, 1'b0, 0);
      checks++;
      if (n_cnt !== 1 || n_ld !== 0 || pc !== 8'h40) begin
         errors++;
         $display("FAIL jz0 got cnt=%0d ld=%0d pc=%h want 1 0 40", n_cnt, n_ld, pc);
      end
      do_instr(5'b0, 8'h00, 1'b0, 2);
      checks++;
      if (n_ex !== 3 || cyc !== 5 || n_cnt !== 1 || n_ld !== 0) begin
         errors++;
         $display("FAIL busy got ex=%0d cyc=%0d cnt=%0d ld=%0d want 3 5 1 0",
                  n_ex, cyc, n_cnt, n_ld);
      end
      checks++;
      if (pc !== 8'h41) begin errors++; $display("FAIL busy_pc got %h want 41", pc); end
      do_instr(5'b00001, 8'h10, 1'b1, 0);
      checks++;
      if (n_ld !== 1 || n_cnt !== 0 || pc !== 8'h10) begin
         errors++;
         $display("FAIL jz1 got ld=%0d cnt=%0d pc=%h want 1 0 10", n_ld, n_cnt, pc);
      end
   endtask

   task automatic test_call_ret();
      do_instr(5'b00100, 8'h80, 1'b0, 0);
      checks++;
      if (pc !== 8'h80 || bus.stack_lvl !== 3'd1) begin
         errors++;
         $display("FAIL call got pc=%h lvl=%0d want 80 1", pc, bus.stack_lvl);
      end
      do_instr(5'b01000, 8'h00, 1'b0, 0);
      checks++;
      if (pc !== 8'h11 || bus.stack_lvl !== 3'd0 || last_ai !== 8'h11) begin
         errors++;
         $display("FAIL ret got pc=%h lvl=%0d ai=%h want 11 0 11",
                  pc, bus.stack_lvl, last_ai);
      end
      do_instr(5'b00010, 8'hFF, 1'b0, 0);
      do_instr(5'b00110, 8'h20, 1'b0, 0);
      checks++;
      if (pc !== 8'h20 || bus.stack_lvl !== 3'd1) begin
         errors++;
         $display("FAIL callff got pc=%h lvl=%0d want 20 1", pc, bus.stack_lvl);
      end
      do_instr(5'b01000, 8'h00, 1'b0, 0);
      checks++;
      if (pc !== 8'h00 || bus.stack_lvl !== 3'd0) begin
         errors++;
         $display("FAIL retwrap got pc=%h lvl=%0d want 00 0", pc, bus.stack_lvl);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 4; i++) do_instr(5'b00100, 8'(8'h30 + i), 1'b0, 0);
      checks++;
      if (bus.stack_lvl !== 3'd4 || pc !== 8'h33) begin
         errors++;
         $display("FAIL ovf_lvl got lvl=%0d pc=%h want 4 33", bus.stack_lvl, pc);
      end
      do_instr(5'b00100, 8'h50, 1'b0, 0);
      checks++;
      if (bus.err !== 1'b1 || bus.halted !== 1'b1) begin
         errors++;
         $display("FAIL ovf_err got err=%b halt=%b want 1 1", bus.err, bus.halted);
      end
      checks++;
      if (n_ld !== 0 || n_cnt !== 0 || pc !== 8'h33 || bus.stack_lvl !== 3'd4) begin
         errors++;
         $display("FAIL ovf_pc got ld=%0d cnt=%0d pc=%h lvl=%0d want 0 0 33 4",
                  n_ld, n_cnt, pc, bus.stack_lvl);
      end
      do_reset();
   endtask

   task automatic test_underflow_halt();
      do_instr(5'b01000, 8'h00, 1'b0, 0);
      checks++;
      if (bus.err !== 1'b1 || bus.halted !== 1'b1 || n_ld !== 0) begin
         errors++;
         $display("FAIL udf got err=%b halt=%b ld=%0d want 1 1 0",
                  bus.err, bus.halted, n_ld);
      end
      do_reset();
      checks++;
      if (bus.err !== 1'b0 || bus.halted !== 1'b0) begin
         errors++;
         $display("FAIL udf_rst got err=%b halt=%b want 0 0", bus.err, bus.halted);
      end
      do_instr(5'b11000, 8'h00, 1'b0, 0);
      checks++;
      if (bus.halted !== 1'b1 || bus.err !== 1'b0 || n_cnt + n_ld !== 0) begin
         errors++;
         $display("FAIL halt got halt=%b err=%b strobes=%0d want 1 0 0",
                  bus.halted, bus.err, n_cnt + n_ld);
      end
      clear_cnt();
      bus.run = 1'b1;
      for (int k = 0; k < 5; k++) begin sample(); @(negedge clk); end
      checks++;
      if (n_cnt + n_ld + n_ir + n_ex !== 0 || bus.halted !== 1'b1) begin
         errors++;
         $display("FAIL halt_run got strobes=%0d halt=%b want 0 1",
                  n_cnt + n_ld + n_ir + n_ex, bus.halted);
      end
      do_reset();
      checks++;
      if (bus.halted !== 1'b0 || bus.err !== 1'b0 || pc !== 8'h00) begin
         errors++;
         $display("FAIL halt_rst got halt=%b err=%b pc=%h want 0 0 00",
                  bus.halted, bus.err, pc);
      end
   endtask

   task automatic test_rst_mid();
      do_instr(5'b00100, 8'h40, 1'b0, 0);
      do_instr(5'b00100, 8'h60, 1'b0, 0);
      checks++;
      if (bus.stack_lvl !== 3'd2) begin
         errors++; $display("FAIL mid_lvl got %0d want 2", bus.stack_lvl);
      end
      bus.run = 1'b1;
      @(negedge clk);
      bus.run = 1'b0;
      @(negedge clk);
      bus.busy = 1'b1;
      bus.dec_jmp = 1'b1;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.pc_count !== 1'b0 || bus.pc_load !== 1'b0 || bus.exec_en !== 1'b0) begin
         errors++;
         $display("FAIL mid_strobe got cnt=%b ld=%b ex=%b want 0 0 0",
                  bus.pc_count, bus.pc_load, bus.exec_en);
      end
      @(negedge clk);
      rst = 1'b0; idle_inputs();
      #1;
      checks++;
      if (bus.stack_lvl !== 3'd0 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL mid_lvl0 got lvl=%0d err=%b want 0 0", bus.stack_lvl, bus.err);
      end
      checks++;
      if (bus.ir_load !== 1'b0 || bus.exec_en !== 1'b0) begin
         errors++;
         $display("FAIL mid_state got ir=%b ex=%b want 0 0", bus.ir_load, bus.exec_en);
      end
      bus.run = 1'b1;
      @(negedge clk);
      bus.run = 1'b0;
      #1;
      checks++;
      if (bus.ir_load !== 1'b1) begin
         errors++; $display("FAIL mid_fetch got ir=%b want 1", bus.ir_load);
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_jumps();
      test_call_ret();
      test_overflow();
      test_underflow_halt();
      test_rst_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mcu_seq.md
# mcu_seq

Instruction sequencer for the MCU. Runs the fetch/decode/execute cycle and is the only driver of the program counter's `count`, `load` and `addr_in` inputs. Resolves jumps, conditional jumps, calls and returns using an internal return-address stack. Sits between the `pc`, the instruction memory and the decoder/datapath.

## Interface

Parameters:
- `INST_DEPTH`, default `` `INST_DEPTH `` (8 in the test build): program address width.
- `SP_W`, default 2: stack pointer width. Stack depth is 2**SP_W.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  allows a new fetch to start.
- `pc_addr`  in  INST_DEPTH  current address, from pc `addr_out`.
- `dec_halt`, `dec_ret`, `dec_call`, `dec_jmp`, `dec_jz`  in  1 each  decoded instruction class; valid during EXEC.
- `dec_target`  in  INST_DEPTH  jump/call target; valid during EXEC.
- `zero`  in  1  datapath zero flag; sampled in the EXEC exit cycle.
- `busy`  in  1  datapath needs more EXEC cycles.
- `pc_count`  out  1  to pc `count`.
- `pc_load`  out  1  to pc `load`.
- `pc_addr_in`  out  INST_DEPTH  to pc `addr_in`.
- `ir_load`  out  1  instruction register capture strobe.
- `exec_en`  out  1  datapath execute enable.
- `halted`  out  1  sequencer is in HALT.
- `err`  out  1  stack overflow or underflow (sticky).
- `stack_lvl`  out  SP_W+1  number of stacked return addresses.

## Operation

- FSM states: FETCH, DECODE, EXEC, HALT.
- **Reset:** state = FETCH. All outputs are 0. `pc_addr_in` = 0. Stack is emptied (`stack_lvl` = 0).
- **FETCH:**
  - `pc_addr` is presented to the instruction memory.
  - Go to DECODE if `run`=1; otherwise stay in FETCH.
- **DECODE:**
  - `ir_load`=1 for exactly one cycle. Memory data is captured here (1-cycle synchronous read).
  - Always go to EXEC.
- **EXEC:**
  - `exec_en`=1 in every EXEC cycle.
  - Stay in EXEC while `busy`=1.
  - The cycle in which `busy`=0 is the exit cycle. It resolves the instruction using this priority:
  - halt: go to HALT. No pc strobe.
  - ret, stack empty: `err`←1, go to HALT.
  - ret, otherwise: pop. `pc_load`=1, `pc_addr_in`=popped value. Go to FETCH.
  - call, stack full: `err`←1, go to HALT. No push, no pc strobe.
  - call, otherwise: push `pc_addr`+1 (mod 2**INST_DEPTH). `pc_load`=1, `pc_addr_in`=`dec_target`. Go to FETCH.
  - jmp: `pc_load`=1, `pc_addr_in`=`dec_target`. Go to FETCH.
  - jz with `zero`=1: same as jmp.
  - jz with `zero`=0, or no flag set: `pc_count`=1. Go to FETCH.
- **HALT:** absorbing state; only `rst` exits it. `halted`=1. No strobes are issued.
- `pc_count` and `pc_load` are never asserted together. Each is asserted only in the EXEC exit cycle.
- `pc_addr_in` holds its last value when `pc_load`=0.

## Timing

- Outputs are combinational decodes of the state and inputs. `stack_lvl`, `err` and `halted` are registered.
- Minimum rate is 3 cycles per instruction (FETCH, DECODE, EXEC). Each `busy` cycle adds one.
- The pc updates on the edge that ends the exit cycle, so the next FETCH sees the new address.
- A push or pop takes effect on the same edge. `stack_lvl` changes in the following cycle.
- Address wrap-around: 2**INST_DEPTH-1 + 1 = 0. This applies to both count and pushed return addresses.
- `rst` overrides everything, in any state including mid-EXEC with `busy`=1. On the next cycle: FETCH state, empty stack, `err`=0.
- `run` is examined only in FETCH. Dropping `run` mid-instruction does not stall it.

## Test plan

All scenarios use INST_DEPTH=8 and SP_W=2.

- **Reset and sequential run:** `rst` for 1 cycle, then `run`=1 with no decode flags. Expect `pc_count` pulses every 3rd cycle and `pc_addr` to step 0,1,2,3. Outputs must be 0 during reset.
- **Jumps and stall:**
  - jmp with `dec_target`=8'h3F at pc=5: `pc_load` pulse, next FETCH sees 0x3F.
  - jz with `zero`=0 at pc=0x3F: next address 0x40.
  - `busy`=1 for 2 cycles: `exec_en` held for 3 cycles and a single strobe.
- **Call/return:** call to 0x80 at pc=0x10, then ret at 0x80. Expect `stack_lvl` 1 then 0, and execution resumes at 0x11. A call at pc=0xFF must push 0x00.
- **Overflow:** 4 nested calls give `stack_lvl`=4. A 5th call gives `err`=1, `halted`=1, no `pc_load`, and pc stays unchanged.
- **Underflow and halt:** ret with empty stack gives `err`=1 and `halted`=1. Separately, a halt instruction gives `halted`=1 with `err`=0. Further `run` causes no strobes; `rst` returns to FETCH with `err`=0.
- **Reset mid-operation:** assert `rst` in EXEC with `busy`=1 and `stack_lvl`=2. Expect no strobe in that cycle, then `stack_lvl`=0 and state FETCH.
